adder_slice_seq_ctrl: RTL and testbench

- Multi-cycle sequencer that computes a NIB*W-bit addition by time-sharing one W-bit adder partition slice, one nibble per cycle, least-significant first, with carry chained between nibbles.
- A per-nibble mask selects, for each nibble, the external approximate slice result or the internally computed exact W-bit sum.
- Also counts nibbles where the approximate and exact results differ, for error characterisation of approximate partitions.
- Sits between the test/characterisation front end and the external approximate partition slice.

---
 rtl/adder_slice_seq_ctrl.sv | 81 ++++++++
 tb/tb_adder_slice_seq_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/adder_slice_seq_ctrl.sv
// adder_slice_seq_ctrl: computes a NIB*W-bit sum one W-bit nibble per cycle on a shared slice,
// with per-nibble override by an external approximate slice and a count of differing nibbles.
module adder_slice_seq_ctrl #(
   parameter int NIB = 8,
   parameter int W   = 4,
   localparam int CW = $clog2(NIB + 1),
   localparam int IW = (NIB > 1) ? $clog2(NIB) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [NIB*W-1:0] a,
   input  logic [NIB*W-1:0] b,
   input  logic             cin,
   input  logic [NIB-1:0]   approx_mask,
   output logic             slice_en,
   output logic [W-1:0]     slice_a,
   output logic [W-1:0]     slice_b,
   output logic             slice_cin,
   input  logic [W-1:0]     slice_sum,
   input  logic             slice_cout,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [NIB*W-1:0] sum,
   output logic             cout,
   output logic [CW-1:0]    mismatch_cnt
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t           state, state_nx;
   logic [NIB*W-1:0] a_q, b_q;
   logic [NIB-1:0]   mask_q;
   logic             carry;
   logic [IW-1:0]    idx;
   logic [W:0]       exact, sel;
   logic             last, use_approx;

   always_ff @(posedge clk)
      state <= rst ? IDLE : state_nx;

   always_comb begin
      state_nx   = (state == IDLE && in_valid) ? RUN :
                   (state == RUN && last) ? DONE :
                   (state == DONE && out_ready) ? IDLE : state;
      in_ready   = state == IDLE && !rst;
      slice_en   = state == RUN;
      out_valid  = state == DONE;
      slice_a    = a_q[W*idx +: W];
      slice_b    = b_q[W*idx +: W];
      slice_cin  = carry;
      last       = idx == IW'(NIB - 1);
      use_approx = mask_q[idx];
      exact      = {1'b0, slice_a} + {1'b0, slice_b} + (W+1)'(slice_cin);
      sel        = use_approx ? {slice_cout, slice_sum} : exact;
   end

   // Datapath: latch on accept, then write one selected nibble per RUN cycle
   always_ff @(posedge clk)
      if (rst) begin
         sum          <= '0;
         cout         <= 1'b0;
         mismatch_cnt <= '0;
         idx          <= '0;
         carry        <= 1'b0;
      end else if (state == IDLE && in_valid) begin
         a_q          <= a;
         b_q          <= b;
         mask_q       <= approx_mask;
         carry        <= cin;
         idx          <= '0;
         sum          <= '0;
         cout         <= 1'b0;
         mismatch_cnt <= '0;
      end else if (state == RUN) begin
         sum[W*idx +: W] <= sel[W-1:0];
         carry           <= sel[W];
         if (use_approx && sel != exact) mismatch_cnt <= mismatch_cnt + 1'b1;
         if (last) cout <= sel[W];
         idx <= last ? '0 : idx + 1'b1;
      end
endmodule

// File: tb/tb_adder_slice_seq_ctrl.sv
// tb_adder_slice_seq_ctrl: directed vectors with hand-computed results for the nibble-serial adder.
module tb_adder_slice_seq_ctrl;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] a = '0, b = '0;
   logic        cin = 1'b0;
   logic [7:0]  approx_mask = '0;
   logic        slice_en;
   logic [3:0]  slice_a, slice_b;
   logic        slice_cin;
   logic [3:0]  slice_sum = 4'hA;
   logic        slice_cout = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] sum;
   logic        cout;
   logic [3:0]  mismatch_cnt;
   int          checks = 0, errors = 0;
   int          lat, t, t1, t2;
   logic        fcin;

   adder_slice_seq_ctrl #(.NIB(8), .W(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .approx_mask(approx_mask),
      .slice_en(slice_en), .slice_a(slice_a), .slice_b(slice_b), .slice_cin(slice_cin),
      .slice_sum(slice_sum), .slice_cout(slice_cout),
      .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .mismatch_cnt(mismatch_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge with in_ready high; returns at the negedge of the first RUN cycle
   task automatic start_op(input logic [31:0] ta, input logic [31:0] tb, input logic tc,
                           input logic [7:0] tm, output logic first_cin);
      a = ta; b = tb; cin = tc; approx_mask = tm; in_valid = 1'b1;
      @(negedge clk);
      in_valid  = 1'b0;
      first_cin = slice_cin;
   endtask

   // Counts clock edges from the accept edge until out_valid is seen
   task automatic wait_done(output int l);
      l = 1;
      while (!out_valid && l < 40) begin
         @(negedge clk);
         l++;
      end
   endtask

   task automatic consume;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("consume_out_valid", out_valid, 0);
      chk("consume_in_ready", in_ready, 1);
   endtask

   initial begin
      @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_slice_en", slice_en, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_sum", sum, 0);
      chk("rst_cout", cout, 0);
      chk("rst_mcnt", mismatch_cnt, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_in_ready", in_ready, 1);

      start_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 8'h00, fcin);
      chk("t1_slice_en", slice_en, 1);
      wait_done(lat);
      chk("t1_latency", lat, 9);
      chk("t1_sum", sum, 32'h0000_0000);
      chk("t1_cout", cout, 1);
      chk("t1_mcnt", mismatch_cnt, 0);
      consume();

      start_op(32'h1234_5678, 32'h1111_1111, 1'b1, 8'h00, fcin);
      chk("t2_first_cin", fcin, 1);
      wait_done(lat);
      chk("t2_sum", sum, 32'h2345_678A);
      chk("t2_cout", cout, 0);
      chk("t2_mcnt", mismatch_cnt, 0);
      consume();

      start_op(32'h0000_000F, 32'h0000_0001, 1'b0, 8'h01, fcin);
      wait_done(lat);
      chk("t3_sum", sum, 32'h0000_000A);
      chk("t3_cout", cout, 0);
      chk("t3_mcnt", mismatch_cnt, 1);
      consume();

      start_op(32'h1111_1111, 32'h2222_2222, 1'b0, 8'h00, fcin);
      a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; cin = 1'b1; approx_mask = 8'hFF; in_valid = 1'b1;
      chk("t4_busy_ready0", in_ready, 0);
      @(negedge clk);
      chk("t4_busy_ready1", in_ready, 0);
      in_valid = 1'b0;
      wait_done(lat);
      for (int i = 0; i < 5; i++) begin
         chk("t4_hold_valid", out_valid, 1);
         chk("t4_hold_sum", sum, 32'h3333_3333);
         chk("t4_hold_mcnt", mismatch_cnt, 0);
         chk("t4_hold_ready", in_ready, 0);
         @(negedge clk);
      end
      consume();

      start_op(32'h1234_5678, 32'h1111_1111, 1'b0, 8'h00, fcin);
      repeat (3) @(negedge clk);
      chk("t5_run4_en", slice_en, 1);
      rst = 1'b1;
      @(negedge clk);
      chk("t5_slice_en", slice_en, 0);
      chk("t5_out_valid", out_valid, 0);
      chk("t5_sum", sum, 0);
      chk("t5_mcnt", mismatch_cnt, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("t5_idle", in_ready, 1);
      start_op(32'h0000_0001, 32'h0000_0002, 1'b0, 8'h00, fcin);
      wait_done(lat);
      chk("t5_sum_after", sum, 32'h0000_0003);
      consume();

      out_ready = 1'b1;
      a = 32'h0000_000F; b = 32'h0000_0001; cin = 1'b0; approx_mask = 8'h01; in_valid = 1'b1;
      t = 0; t1 = -1; t2 = -1;
      while (t2 < 0 && t < 100) begin
         if (in_valid && in_ready) begin
            if (t1 < 0) t1 = t;
            else t2 = t;
         end
         if (out_valid) begin
            chk("t6_first_sum", sum, 32'h0000_000A);
            chk("t6_first_mcnt", mismatch_cnt, 1);
         end
         if (t2 < 0) begin
            @(negedge clk);
            t++;
            if (t1 >= 0) begin
               a = 32'h0000_0001; b = 32'h0000_0001; approx_mask = 8'h00;
            end
         end
      end
      chk("t6_spacing", t2 - t1, 10);
      @(negedge clk);
      in_valid = 1'b0;
      wait_done(lat);
      chk("t6_second_valid", out_valid, 1);
      chk("t6_second_sum", sum, 32'h0000_0002);
      chk("t6_second_mcnt", mismatch_cnt, 0);
      out_ready = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
